alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the Beta combinational ALU.
- Keeps the 6-bit Beta fn encoding for compare, arithmetic, boolean and shift operations, and adds iterative signed MUL and DIV.
- Registers the result behind valid/ready so the execute stage can stall on multi-cycle operations.
- Sits between the register-read and writeback stages of the pipelined Beta core.

Parameters:
- WIDTH, 32: operand and result width in bits; must be a power of 2, at least 8.
- SHAMT_W, $clog2(WIDTH): shift-amount width, taken from b[SHAMT_W-1:0].

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- fn  in  6  function code (Beta encoding, below).
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- y  out  WIDTH  result.
- out_dz  out  1  result came from DIV with b==0.
- out_illegal  out  1  fn was an unsupported code.
- busy  out  1  MUL or DIV iteration in progress.

Behaviour:
- Reset (async, immediate): state=IDLE, out_valid=0, y=0, out_dz=0, out_illegal=0, busy=0. Any in-flight MUL/DIV is discarded; no result is produced for it.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - fn, a and b are captured at accept; later input changes are ignored.
- fn decode, by fn[5:4]:
  - 00 compare, CMP = {WIDTH-1 zeros, lsb} of a-b:
    - fn[2:1]=01 → EQ: zero.
    - fn[2:1]=10 → LT: neg^ov.
    - fn[2:1]=11 → LE: zero|(neg^ov).
    - fn[2:1]=00 → illegal.
  - 01 arithmetic:
    - fn[1:0]=00 → ADD a+b.
    - 01 → SUB a-b.
    - 10 → MUL.
    - 11 → DIV.
    - fn[3:2] are ignored.
  - 10 boolean: bit i = fn[{b[i],a[i]}], i.e. a per-bit truth table from fn[3:0].
  - 11 shift:
    - fn[1:0]=00 → SHL.
    - 01 → SHR (logical).
    - 11 → SRA.
    - 10 → illegal.
- Illegal fn: completes as a single-cycle op with y=0, out_illegal=1.
- Single-cycle ops (compare, ADD, SUB, boolean, shift, illegal):
  - Accepted at edge k → out_valid=1 and y valid from edge k+1.
  - Back-to-back accepts give a throughput of 1 per cycle while out_ready=1.
- MUL: signed, result = low WIDTH bits of a*b (wraps).
  - Iterative, one bit per cycle; state MUL, busy=1.
  - Accepted at edge k → out_valid from edge k+WIDTH.
- DIV: signed, quotient truncates toward zero.
  - Restoring division on magnitudes, one bit per cycle, then one sign-fix cycle; state DIV, busy=1.
  - Accepted at edge k → out_valid from edge k+WIDTH+1.
  - b==0: full latency still applies; y = all ones, out_dz=1.
  - Most-negative / -1: y = most-negative (wraps), out_dz=0.
- States and transitions:
  - IDLE→MUL or IDLE→DIV on accept of MUL/DIV.
  - MUL/DIV→IDLE on the final iteration edge, which also sets out_valid.
- Output hold: while out_valid && !out_ready, y, out_dz and out_illegal hold stable and in_ready=0.
  - A MUL/DIV completion cannot collide with an unconsumed result, because in_ready required the output slot to be free at accept.
- Output clear: out_valid clears on an edge with out_valid && out_ready unless a new single-cycle op is accepted on the same edge, in which case it stays 1 with new data.
- Flags: out_dz and out_illegal are 0 for all other results.
- Overflow: ADD/SUB wrap modulo 2^WIDTH. The ov used by compares is computed on a and ~b with carry-in 1 (signed overflow of a-b).

Test Plan:
- WIDTH=32, back-to-back ADD 7+5, SUB 3-5, CMPLT -1<1, SRA 0x80000000>>4 with out_ready=1 → y=12, 0xFFFFFFFE, 1, 0xF8000000 on 4 consecutive cycles; in_ready stays 1.
- MUL -3*7 accepted at edge k → y=0xFFFFFFEB, out_valid first high at k+32, busy=1 and in_ready=0 throughout.
- DIV -7/2 → y=0xFFFFFFFD at k+33.
- DIV 5/0 → y=0xFFFFFFFF, out_dz=1.
- DIV 0x80000000/-1 → y=0x80000000, out_dz=0.
- Hold out_ready=0 for 5 cycles after an ADD result; offer a new op meanwhile → y stable, in_ready=0, new op accepted only after out_ready=1.
- fn=6'b111110 (illegal shift) → y=0, out_illegal=1 next cycle.
- Assert rst 10 cycles into a DIV → out_valid=0, y=0 and busy=0 immediately; next op completes normally.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered Beta ALU with iterative signed MUL and DIV.
//
// Single-cycle ops (compare, ADD/SUB, boolean, shift, illegal codes) are
// registered at the accept edge. MUL takes WIDTH shift-add iterations and
// DIV takes WIDTH restoring-division iterations plus one sign-fix cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake; fn, a, b captured at accept
//   fn                  6-bit Beta function code
//   a, b                operands
//   out_valid/out_ready result handshake
//   y                   result
//   out_dz              result came from DIV with b==0
//   out_illegal         fn was an unsupported code
//   busy                MUL/DIV iteration in progress
module alu_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_dz,
  output logic             out_illegal,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] y_q;
  logic             out_valid_q;
  logic             out_dz_q;
  logic             out_illegal_q;
  logic [CNT_W-1:0] cnt_q;

  // MUL working registers
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;

  // DIV working registers (magnitudes; sign applied in the final cycle)
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] rem_q;
  logic             q_neg_q;
  logic             dz_q;

  logic accept;

  // ---------------- single-cycle decode ----------------
  logic [WIDTH-1:0]   res;
  logic               illegal;
  logic               start_mul;
  logic               start_div;
  logic [WIDTH-1:0]   diff;
  logic               zero;
  logic               neg;
  logic               ov;
  logic               lt;
  logic [3:0]         tt;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   sra;

  always_comb begin
    res       = '0;
    illegal   = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    diff      = a - b;
    zero      = (diff == '0);
    neg       = diff[WIDTH-1];
    // signed overflow of a-b: operand signs differ and result sign differs from a
    ov        = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    lt        = neg ^ ov;
    tt        = fn[3:0];
    shamt     = b[SHAMT_W-1:0];
    sra       = $unsigned($signed(a) >>> shamt);
    unique case (fn[5:4])
      2'b00: begin
        unique case (fn[2:1])
          2'b01:   res[0] = zero;
          2'b10:   res[0] = lt;
          2'b11:   res[0] = zero | lt;
          default: illegal = 1'b1;
        endcase
      end
      2'b01: begin
        unique case (fn[1:0])
          2'b00:   res = a + b;
          2'b01:   res = diff;
          2'b10:   start_mul = 1'b1;
          default: start_div = 1'b1;
        endcase
      end
      2'b10: begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
          res[i] = tt[{b[i], a[i]}];
        end
      end
      default: begin
        unique case (fn[1:0])
          2'b00:   res = a << shamt;
          2'b01:   res = a >> shamt;
          2'b11:   res = sra;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

  // ---------------- iteration datapath ----------------
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             take;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, dvsr_q};
    // no borrow out of the (WIDTH+1)-bit subtract means rem_sh >= divisor
    take     = !rem_sub[WIDTH];
    a_mag    = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_mag    = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = !out_valid_q || out_ready;
        accept   = in_valid && in_ready;
        if (accept && start_mul)      state_d = MUL;
        else if (accept && start_div) state_d = DIV;
      end
      MUL: begin
        busy = 1'b1;
        if (cnt_q == MUL_LAST) state_d = IDLE;
      end
      DIV: begin
        busy = 1'b1;
        if (cnt_q == DIV_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q           <= '0;
      out_valid_q   <= 1'b0;
      out_dz_q      <= 1'b0;
      out_illegal_q <= 1'b0;
      cnt_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      acc_q         <= '0;
      quo_q         <= '0;
      dvsr_q        <= '0;
      rem_q         <= '0;
      q_neg_q       <= 1'b0;
      dz_q          <= 1'b0;
    end else begin
      // Later assignments (new single-cycle result, MUL/DIV completion)
      // override this consume-clear on the same edge.
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;

      if (accept) begin
        cnt_q <= '0;
        if (start_mul) begin
          mcand_q  <= a;
          mplier_q <= b;
          acc_q    <= '0;
        end else if (start_div) begin
          quo_q   <= a_mag;
          dvsr_q  <= b_mag;
          rem_q   <= '0;
          q_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
          dz_q    <= (b == '0);
        end else begin
          y_q           <= res;
          out_valid_q   <= 1'b1;
          out_dz_q      <= 1'b0;
          out_illegal_q <= illegal;
        end
      end

      if (state_q == MUL) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (cnt_q == MUL_LAST) begin
          y_q           <= acc_next;
          out_valid_q   <= 1'b1;
          out_dz_q      <= 1'b0;
          out_illegal_q <= 1'b0;
        end
      end

      if (state_q == DIV) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == DIV_LAST) begin
          // sign-fix cycle; negating the most-negative magnitude wraps to itself
          y_q           <= dz_q ? '1 : (q_neg_q ? (~quo_q + WIDTH'(1)) : quo_q);
          out_valid_q   <= 1'b1;
          out_dz_q      <= dz_q;
          out_illegal_q <= 1'b0;
        end else begin
          quo_q <= {quo_q[WIDTH-2:0], take};
          rem_q <= take ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        end
      end
    end
  end

  assign y           = y_q;
  assign out_valid   = out_valid_q;
  assign out_dz      = out_dz_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32).
module tb_alu_seq;
  localparam int W = 32;

  localparam logic [5:0] F_ADD   = 6'h10;
  localparam logic [5:0] F_SUB   = 6'h11;
  localparam logic [5:0] F_MUL   = 6'h12;
  localparam logic [5:0] F_DIV   = 6'h13;
  localparam logic [5:0] F_CMPEQ = 6'h02;
  localparam logic [5:0] F_CMPLT = 6'h04;
  localparam logic [5:0] F_CMPLE = 6'h06;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_AND   = 6'h28;
  localparam logic [5:0] F_SHL   = 6'h30;
  localparam logic [5:0] F_SHR   = 6'h31;
  localparam logic [5:0] F_SRA   = 6'h33;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   fn = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] y;
  logic         out_dz;
  logic         out_illegal;
  logic         busy;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fn(fn), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .out_dz(out_dz), .out_illegal(out_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with out_ready=1, then wait (bounded) for its result.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] x,
                        input logic [W-1:0] z, input logic [W-1:0] ey, input logic edz,
                        input logic eill, input int lat);
    int  n;
    logic ok;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    fn = f; a = x; b = z;
    chk({tag, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    fn = F_ADD; a = $urandom; b = $urandom;
    n  = 0;
    ok = 1'b1;
    while (!out_valid && n < 100) begin
      if (!(busy === 1'b1 && in_ready === 1'b0)) ok = 1'b0;
      tick();
      n++;
    end
    if (lat > 0) chk({tag, "_busy_stall"}, ok, 1);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_dz"}, out_dz, edz);
    chk({tag, "_illegal"}, out_illegal, eill);
    chk({tag, "_busy_done"}, busy, 0);
  endtask

  initial begin
    logic ok;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {out_dz, out_illegal}, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // back-to-back single-cycle ops
    out_ready = 1'b1;
    in_valid = 1'b1; fn = F_ADD; a = 7; b = 5;
    chk("b2b_rdy0", in_ready, 1);
    tick();
    chk("b2b_add", y, 32'd12);
    chk("b2b_rdy1", in_ready, 1);
    fn = F_SUB; a = 3; b = 5;
    tick();
    chk("b2b_sub", y, 32'hFFFF_FFFE);
    chk("b2b_rdy2", in_ready, 1);
    fn = F_CMPLT; a = 32'hFFFF_FFFF; b = 1;
    tick();
    chk("b2b_cmplt", y, 32'd1);
    chk("b2b_rdy3", in_ready, 1);
    fn = F_SRA; a = 32'h8000_0000; b = 4;
    tick();
    chk("b2b_sra", y, 32'hF800_0000);
    chk("b2b_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", out_valid, 0);

    // more single-cycle patterns
    run_op("cmpeq",   F_CMPEQ, 5, 5, 1, 0, 0, 0);
    run_op("cmple",   F_CMPLE, 3, 2, 0, 0, 0, 0);
    run_op("cmplt_ov", F_CMPLT, 32'h8000_0000, 1, 1, 0, 0, 0);
    run_op("shl",     F_SHL, 1, 32'h23, 32'h8, 0, 0, 0);
    run_op("shr",     F_SHR, 32'h8000_0000, 4, 32'h0800_0000, 0, 0, 0);
    run_op("xor",     F_XOR, 32'hF0F0_1234, 32'h0FF0_1200, 32'hFF00_0034, 0, 0, 0);
    run_op("and",     F_AND, 32'hF0F0_1234, 32'h0FF0_1200, 32'h00F0_1200, 0, 0, 0);
    run_op("add_wrap", F_ADD, 32'hFFFF_FFFF, 2, 1, 0, 0, 0);
    run_op("ill_shift", 6'b111110, 5, 6, 0, 0, 1, 0);
    run_op("ill_cmp",  6'b000000, 5, 6, 0, 0, 1, 0);

    // iterative ops
    run_op("mul_neg",  F_MUL, 32'hFFFF_FFFD, 7, 32'hFFFF_FFEB, 0, 0, 32);
    run_op("mul_wrap", F_MUL, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 0, 0, 32);
    run_op("div_neg",  F_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 0, 0, 33);
    run_op("div_big",  F_DIV, 100, 32'hFFFF_FFFD, 32'hFFFF_FFDF, 0, 0, 33);
    run_op("div_zero", F_DIV, 5, 0, 32'hFFFF_FFFF, 1, 0, 33);
    run_op("div_min",  F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 33);
    run_op("after_dz", F_SUB, 10, 3, 7, 0, 0, 0);

    // output hold under back-pressure
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; fn = F_ADD; a = 1; b = 2;
    tick();
    chk("hold_first", y, 3);
    fn = F_SUB; a = 10; b = 4;
    ok = 1'b1;
    repeat (5) begin
      tick();
      if (!(y === 32'd3 && in_ready === 1'b0 && out_valid === 1'b1)) ok = 1'b0;
    end
    chk("hold_stable", ok, 1);
    out_ready = 1'b1;
    #1;
    chk("hold_release_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("hold_new_y", y, 6);
    chk("hold_new_valid", out_valid, 1);

    // async reset in the middle of a DIV
    in_valid = 1'b1; fn = F_DIV; a = 100; b = 3;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_y", y, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst_add", F_ADD, 40, 2, 42, 0, 0, 0);
    run_op("post_rst_div", F_DIV, 100, 3, 33, 0, 0, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
